// File: rtl/avalon_mm_pkg.sv
// Shared types and constants for the Avalon-MM initiator and its helpers.
package avalon_mm_pkg;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Width needed to count 0..t, never less than one bit.
  function automatic int cnt_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/avalon_mm_wait_timer.sv
// Saturating stall counter; pulses timeout when a stall reaches THRESH cycles.
module avalon_mm_wait_timer
  import avalon_mm_pkg::*;
#(
  parameter int THRESH = 64,
  parameter int W      = cnt_width(THRESH)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] LIM = W'((THRESH == 0) ? 0 : THRESH - 1);

  logic [W-1:0] count;

  // THRESH == 0 disables the watchdog entirely.
  assign timeout = (THRESH != 0) && en && (count == LIM);

  // Count stalled edges; hold at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   count <= '0;
    else if (clr)                count <= '0;
    else if (en && count != MAX) count <= count + 1'b1;
  end

endmodule

// File: rtl/avalon_mm_master.sv
// Single-outstanding Avalon-MM initiator with valid/ready command and response ports.
module avalon_mm_master
  import avalon_mm_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_write,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_error,
  output logic [AW-1:0] address,
  output logic          read,
  output logic          write,
  output logic          chipselect,
  output logic [DW-1:0] writedata,
  input  logic          waitrequest,
  input  logic [DW-1:0] readdata
);

  state_t state;
  logic   tmo;

  // Stall watchdog: counts waitrequest-high edges of the current transfer.
  avalon_mm_wait_timer #(.THRESH(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (state == RESP && rsp_valid && rsp_ready),
    .en      (state == BUS && waitrequest),
    .timeout (tmo)
  );

  // Control FSM; every port output is a register written here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_write  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_error  <= 1'b0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      chipselect <= 1'b0;
      writedata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            address    <= cmd_addr;
            writedata  <= cmd_wdata;
            read       <= ~cmd_write;
            write      <= cmd_write;
            chipselect <= 1'b1;
            cmd_ready  <= 1'b0;
            state      <= BUS;
          end
        end
        BUS: begin
          // Completion beats timeout: waitrequest low means no stall this edge.
          if (!waitrequest) begin
            read       <= 1'b0;
            write      <= 1'b0;
            chipselect <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_write  <= write;
            rsp_rdata  <= write ? '0 : readdata;
            rsp_error  <= 1'b0;
            state      <= RESP;
          end else if (tmo) begin
            read       <= 1'b0;
            write      <= 1'b0;
            chipselect <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_write  <= write;
            rsp_rdata  <= '0;
            rsp_error  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_mm_master.sv
// Directed bench for avalon_mm_master against a small wait-state slave model.
module tb_avalon_mm_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_write, rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] address;
  logic          read, write, chipselect, waitrequest;
  logic [DW-1:0] writedata, readdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  avalon_mm_master #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .address(address), .read(read), .write(write), .chipselect(chipselect),
    .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata)
  );

  // Slave model: mem[i] = i after reset; waitrequest high for wait_cfg cycles, or forever when stuck.
  logic [31:0] mem [0:255];
  int wait_cfg = 0;
  bit stuck = 1'b0;
  int wcnt;

  assign waitrequest = (read | write) && (stuck || wcnt < wait_cfg);
  assign readdata    = mem[address[7:0]];

  always @(posedge clk) begin
    if (reset) begin
      wcnt <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= i;
    end else begin
      if ((read | write) && waitrequest) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (write && chipselect && !waitrequest) mem[address[7:0]] <= writedata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one command, wait for acceptance, then run until rsp_valid.
  // lat = cycles from accept edge to first rsp_valid cycle; bus = active bus cycles.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output int bus, output int badbus);
    int n;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("accept_ready", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1; bus = 0; badbus = 0;
    while (!rsp_valid && lat < 40) begin
      if (cmd_ready) badbus++;
      if (read | write) begin
        bus++;
        if (address != a || read != !wr || write != wr || !chipselect ||
            (wr && writedata != d)) badbus++;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    bit          stk;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_bus;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, bus, badbus, cnt, stable;
    int acc[0:3];
    logic [31:0] rd[0:2];
    int k, r, xf;
    bit pre, xe;

    //           wr  addr   wdata         waits stk  rdata         err lat bus
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0,        1'b0, 2, 1};
    vecs[1] = '{1'b0, 32'h20, 32'h0,        4, 1'b0, 32'h20,       1'b0, 6, 5};
    vecs[2] = '{1'b0, 32'h10, 32'h0,        0, 1'b0, 32'hDEADBEEF, 1'b0, 2, 1};
    vecs[3] = '{1'b0, 32'h30, 32'h0,        0, 1'b1, 32'h0,        1'b1, 9, 8};
    vecs[4] = '{1'b1, 32'h30, 32'h12345678, 7, 1'b0, 32'h0,        1'b0, 9, 8};
    vecs[5] = '{1'b0, 32'h30, 32'h0,        0, 1'b0, 32'h12345678, 1'b0, 2, 1};
    vecs[6] = '{1'b1, 32'h40, 32'h55,       0, 1'b1, 32'h0,        1'b1, 9, 8};
    vecs[7] = '{1'b0, 32'h40, 32'h0,        8, 1'b0, 32'h0,        1'b1, 9, 8};

    // Reset state
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_bus", {61'd0, read, write, chipselect}, 64'd0);
    chk("rst_rsp", {62'd0, rsp_valid, rsp_error}, 64'd0);
    chk("rst_addr", {32'd0, address}, 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven transactions, rsp_ready held high
    for (int i = 0; i < 8; i++) begin
      wait_cfg = vecs[i].waits;
      stuck    = vecs[i].stk;
      issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, bus, badbus);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_bus", i), bus, vecs[i].exp_bus);
      chk($sformatf("v%0d_busval", i), badbus, 0);
      chk($sformatf("v%0d_rdata", i), {32'd0, rsp_rdata}, {32'd0, vecs[i].exp_rdata});
      chk($sformatf("v%0d_err", i), {63'd0, rsp_error}, {63'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_wr", i), {63'd0, rsp_write}, {63'd0, vecs[i].wr});
      @(posedge clk); #1;
      stuck = 1'b0;
      chk($sformatf("v%0d_done", i), {62'd0, rsp_valid, cmd_ready}, 64'd1);
    end

    // Response backpressure: response held, bus idle, no new command taken
    wait_cfg = 0;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h20, 32'h0, lat, bus, badbus);
    chk("bp_lat", lat, 2);
    stable = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_rdata != 32'h20 || cmd_ready || read || write || chipselect)
        stable++;
    end
    chk("bp_stable", stable, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {62'd0, rsp_valid, cmd_ready}, 64'd1);

    // Reset during BUS cycle 2 of a stalled read
    stuck = 1'b1;
    cmd_write = 1'b0; cmd_addr = 32'h50; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_active", {63'd0, read}, 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_bus_off", {61'd0, read, write, chipselect}, 64'd0);
    chk("mid_rsp_off", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk) reset = 1'b0;
    stuck = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid || !cmd_ready || read || chipselect) cnt++;
    end
    chk("mid_no_stale", cnt, 0);

    // Back-to-back: cmd_valid stays high across three commands
    k = 0; r = 0; xf = 0;
    cmd_write = 1'b1; cmd_addr = 32'h1; cmd_wdata = 32'hA; cmd_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      pre = cmd_ready && cmd_valid;
      xe  = (read | write) && !waitrequest;
      @(posedge clk); #1;
      if (xe) xf++;
      if (pre) begin
        acc[k] = c;
        k++;
        if (k == 1) begin cmd_write = 1'b0; cmd_addr = 32'h1; end
        else if (k == 2) begin cmd_write = 1'b0; cmd_addr = 32'h2; end
        else cmd_valid = 1'b0;
      end
      if (rsp_valid && r < 3) begin rd[r] = rsp_rdata; r++; end
    end
    chk("b2b_accepts", k, 3);
    chk("b2b_rsps", r, 3);
    chk("b2b_xfers", xf, 3);
    chk("b2b_gap01", acc[1] - acc[0], 3);
    chk("b2b_gap12", acc[2] - acc[1], 3);
    chk("b2b_rd1", {32'd0, rd[1]}, 64'hA);
    chk("b2b_rd2", {32'd0, rd[2]}, 64'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
